dp_mem_responder: RTL and testbench

Synthesizable dual-port memory responder that answers the pipeline's instruction-fetch and data-memory request/response handshakes. Port A serves instruction fetch and port B serves loads/stores. Each port independently accepts a read or byte-masked write, waits a programmable latency, then pulses `resp`. It replaces the behavioural dual-port memory model so DGM can be simulated and synthesized against identical timing.

---
 rtl/dp_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_dp_mem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_mem_responder.sv
// dp_mem_responder -- dual-port 16-bit memory answering request/response
// handshakes. Port A serves instruction fetch, port B serves loads/stores.
// Each port accepts one read or byte-masked write, waits LATENCY cycles,
// performs the access and pulses resp for one cycle.
//
// Parameters:
//   DEPTH_LOG2 : 2^DEPTH_LOG2 16-bit words, word index = address[DEPTH_LOG2:1]
//   LATENCY    : cycles from acceptance to resp, legal range 1..15
// Ports (x = a | b):
//   clk, rst            : clock, asynchronous active-high reset
//   read_x, write_x     : request strobes, held until resp_x (write wins)
//   wmask_x[1:0]        : byte enables, bit0 -> [7:0], bit1 -> [15:8]
//   address_x[15:0]     : byte address, bit 0 ignored
//   wdata_x[15:0]       : write data
//   resp_x              : one-cycle completion pulse
//   rdata_x[15:0]       : read data, held until the next read completes
// Configuration:
//   DP_MEM_OOR_CHECK_EN : when defined, addresses with any bit above
//                         DEPTH_LOG2 set read as 0 and drop writes; when
//                         undefined, upper address bits are ignored (wrap).
// Array contents are not reset and start undefined; the environment loads
// them through the write ports.

module dp_mem_port_ctl #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  wmask,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic [15:0] rd_word,
    output logic        fire,
    output logic        resp,
    output logic        acc_write,
    output logic [1:0]  acc_mask,
    output logic [15:0] acc_addr,
    output logic [15:0] acc_wdata,
    output logic [15:0] rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        capture;
    logic        write_q;
    logic [1:0]  mask_q;
    logic [15:0] addr_q, wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                write_q <= write;
                mask_q  <= wmask;
                addr_q  <= address;
                wdata_q <= wdata;
            end
            if (fire && !acc_write)
                rdata <= rd_word;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: if (read || write) begin
                capture = 1'b1;
                if (LATENCY == 1) begin
                    fire    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fire    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the accepting edge, before the
    // request is latched, so the live inputs are used while in IDLE.
    assign acc_write = (state_q == IDLE) ? write   : write_q;
    assign acc_mask  = (state_q == IDLE) ? wmask   : mask_q;
    assign acc_addr  = (state_q == IDLE) ? address : addr_q;
    assign acc_wdata = (state_q == IDLE) ? wdata   : wdata_q;
    assign resp      = (state_q == RESP);
endmodule

module dp_mem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_a,
    input  logic        write_a,
    input  logic [1:0]  wmask_a,
    input  logic [15:0] address_a,
    input  logic [15:0] wdata_a,
    output logic        resp_a,
    output logic [15:0] rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b
);
    localparam int NUM_PORTS = 2;

    logic [NUM_PORTS-1:0]                 rd_req, wr_req, fire, resp, acc_write, in_range, wr_en;
    logic [NUM_PORTS-1:0]                 addr_unused;
    logic [NUM_PORTS-1:0][1:0]            wmask, acc_mask;
    logic [NUM_PORTS-1:0][15:0]           addr, wdata, acc_addr, acc_wdata, rd_word, rdata;
    logic [NUM_PORTS-1:0][DEPTH_LOG2-1:0] idx;

    logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];

    assign rd_req = {read_b, read_a};
    assign wr_req = {write_b, write_a};
    assign wmask  = {wmask_b, wmask_a};
    assign addr   = {address_b, address_a};
    assign wdata  = {wdata_b, wdata_a};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        dp_mem_port_ctl #(.LATENCY(LATENCY)) u_ctl (
            .clk       (clk),
            .rst       (rst),
            .read      (rd_req[p]),
            .write     (wr_req[p]),
            .wmask     (wmask[p]),
            .address   (addr[p]),
            .wdata     (wdata[p]),
            .rd_word   (rd_word[p]),
            .fire      (fire[p]),
            .resp      (resp[p]),
            .acc_write (acc_write[p]),
            .acc_mask  (acc_mask[p]),
            .acc_addr  (acc_addr[p]),
            .acc_wdata (acc_wdata[p]),
            .rdata     (rdata[p])
        );

        assign idx[p] = acc_addr[p][DEPTH_LOG2:1];
`ifdef DP_MEM_OOR_CHECK_EN
        assign in_range[p] = ((acc_addr[p] >> (DEPTH_LOG2 + 1)) == 16'h0000);
`else
        assign in_range[p] = 1'b1;
`endif
        // Bit 0 (and the upper bits without the range check) never index.
        assign addr_unused[p] = ^acc_addr[p];
        // Asynchronous array read; registered into rdata on the access edge,
        // which gives read-before-write against a same-edge write.
        assign rd_word[p] = in_range[p] ? mem[idx[p]] : 16'h0000;
        assign wr_en[p]   = fire[p] & acc_write[p] & in_range[p] & ~rst;
    end

    // Port B is written first so port A's bytes override on overlap.
    always_ff @(posedge clk) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                if (acc_mask[p][0]) mem[idx[p]][7:0]  <= acc_wdata[p][7:0];
                if (acc_mask[p][1]) mem[idx[p]][15:8] <= acc_wdata[p][15:8];
            end
        end
    end

    assign resp_a  = resp[0];
    assign resp_b  = resp[1];
    assign rdata_a = rdata[0];
    assign rdata_b = rdata[1];
endmodule

// File: tb/tb_dp_mem_responder.sv
module tb_dp_mem_responder;
    localparam int LAT = 2;
    localparam int DL  = 12;

    logic        clk, rst;
    logic        rd [2];
    logic        wr [2];
    logic [1:0]  msk [2];
    logic [15:0] adr [2];
    logic [15:0] wd [2];
    logic        resp [2];
    logic [15:0] rdat [2];

    int nvec = 0;
    int nerr = 0;

    dp_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .read_a(rd[0]), .write_a(wr[0]), .wmask_a(msk[0]), .address_a(adr[0]),
        .wdata_a(wd[0]), .resp_a(resp[0]), .rdata_a(rdat[0]),
        .read_b(rd[1]), .write_b(wr[1]), .wmask_b(msk[1]), .address_b(adr[1]),
        .wdata_b(wd[1]), .resp_b(resp[1]), .rdata_b(rdat[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction-level: each accepted request is stamped with the edge at
    // which its access lands and the earliest edge the port can accept again.
    logic [15:0] mmem [0:(1<<DL)-1];
    bit          pend [2];
    int          due [2];
    int          free_at [2];
    bit          mw [2];
    logic [15:0] ma [2], md [2];
    logic [1:0]  mm [2];
    logic        exp_resp [2];
    logic [15:0] exp_rdata [2];
    int          ecnt;

    function automatic bit in_rng(input logic [15:0] a);
`ifdef DP_MEM_OOR_CHECK_EN
        return (a >> (DL + 1)) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(input logic [15:0] a);
        return int'(a[DL:1]);
    endfunction

    initial begin
        ecnt = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; due[p] = 0; free_at[p] = 0;
            exp_resp[p] = 0; exp_rdata[p] = 16'h0000;
        end
        forever begin
            @(posedge clk);
            ecnt++;
            if (rst) begin
                for (int p = 0; p < 2; p++) begin
                    pend[p] = 0; free_at[p] = 0;
                    exp_resp[p] = 0; exp_rdata[p] = 16'h0000;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    exp_resp[p] = 0;
                    if (!pend[p] && ecnt >= free_at[p] && (rd[p] || wr[p])) begin
                        pend[p] = 1; mw[p] = wr[p]; ma[p] = adr[p]; mm[p] = msk[p]; md[p] = wd[p];
                        due[p] = ecnt + LAT - 1;
                        free_at[p] = ecnt + LAT + 1;
                    end
                end
                for (int p = 0; p < 2; p++)
                    if (pend[p] && due[p] == ecnt && !mw[p])
                        exp_rdata[p] = in_rng(ma[p]) ? mmem[widx(ma[p])] : 16'h0000;
                for (int p = 1; p >= 0; p--)
                    if (pend[p] && due[p] == ecnt && mw[p] && in_rng(ma[p])) begin
                        if (mm[p][0]) mmem[widx(ma[p])][7:0]  = md[p][7:0];
                        if (mm[p][1]) mmem[widx(ma[p])][15:8] = md[p][15:8];
                    end
                for (int p = 0; p < 2; p++)
                    if (pend[p] && due[p] == ecnt) begin
                        exp_resp[p] = 1; pend[p] = 0;
                    end
            end
            #1;
            for (int p = 0; p < 2; p++) begin
                check($sformatf("model resp%0d", p), 16'(resp[p]), 16'(exp_resp[p]));
                check($sformatf("model rdata%0d", p), rdat[p], exp_rdata[p]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input int p, input bit w, input logic [15:0] a, input logic [1:0] m,
                       input logic [15:0] d, output logic [15:0] q, output int lat);
        @(negedge clk);
        rd[p] = !w; wr[p] = w; adr[p] = a; msk[p] = m; wd[p] = d;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!resp[p] && lat < 40);
        if (!resp[p]) begin
            nvec++; nerr++;
            $display("FAIL timeout port%0d: no resp after %0d cycles", p, lat);
        end
        q = rdat[p];
        @(negedge clk);
        rd[p] = 0; wr[p] = 0;
    endtask

    task automatic rand_port(input int p, input int n);
        logic [15:0] q, a;
        int lat;
        for (int i = 0; i < n; i++) begin
            a = 16'($urandom_range(0, 15) << 1) | 16'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = a | 16'h8000;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            req(p, bit'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 16'($urandom), q, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q, q2;
        int lat, n;
        bit saw;
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            rd[p] = 0; wr[p] = 0; msk[p] = 0; adr[p] = 0; wd[p] = 0;
        end
        repeat (3) @(negedge clk);
        check("reset resp_a", 16'(resp[0]), 16'h0);
        check("reset resp_b", 16'(resp[1]), 16'h0);
        check("reset rdata_a", rdat[0], 16'h0000);
        check("reset rdata_b", rdat[1], 16'h0000);
        rst = 1'b0;

        // preload the words used below
        for (int w = 0; w < 16; w++) req(0, 1, 16'(w << 1), 2'b11, 16'($urandom), q, lat);
        req(0, 1, 16'h0020, 2'b11, 16'hBEEF, q, lat);
        req(0, 1, 16'h0100, 2'b11, 16'h0000, q, lat);
        req(0, 1, 16'h0002, 2'b11, 16'h5555, q, lat);
        req(1, 1, 16'h0000, 2'b11, 16'hC0DE, q, lat);

        // read latency
        req(0, 0, 16'h0020, 2'b00, 16'h0, q, lat);
        check("read latency", 16'(lat), 16'(LAT));
        check("read data BEEF", q, 16'hBEEF);
        @(posedge clk); #1;
        check("resp_a one cycle", 16'(resp[0]), 16'h0);

        // byte-masked write
        req(0, 1, 16'h0040, 2'b11, 16'h1234, q, lat);
        req(0, 1, 16'h0040, 2'b10, 16'hAB00, q, lat);
        req(1, 0, 16'h0040, 2'b00, 16'h0, q, lat);
        check("masked write", q, 16'hAB34);

        // same-word collisions
        fork
            req(0, 1, 16'h0100, 2'b01, 16'h1111, q, lat);
            req(1, 1, 16'h0100, 2'b11, 16'h2222, q2, n);
        join
        req(0, 0, 16'h0100, 2'b00, 16'h0, q, lat);
        check("collision write", q, 16'h2211);
        fork
            req(0, 0, 16'h0100, 2'b00, 16'h0, q, lat);
            req(1, 1, 16'h0100, 2'b11, 16'h3333, q2, n);
        join
        check("read-before-write", q, 16'h2211);
        req(1, 0, 16'h0100, 2'b00, 16'h0, q, lat);
        check("post-collision read", q, 16'h3333);

        // back-to-back with read_b held
        @(negedge clk);
        rd[1] = 1; adr[1] = 16'h0020;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!resp[1] && n < 40);
        check("b2b first data", rdat[1], 16'hBEEF);
        @(negedge clk);
        adr[1] = 16'h0040;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!resp[1] && n < 40);
        check("b2b spacing", 16'(n), 16'(LAT + 1));
        check("b2b second data", rdat[1], 16'hAB34);
        @(negedge clk);
        rd[1] = 0;

        // reset during BUSY of a write
        @(negedge clk);
        wr[0] = 1; adr[0] = 16'h0002; msk[0] = 2'b11; wd[0] = 16'hFFFF;
        @(negedge clk);
        rst = 1'b1;
        saw = 0;
        @(negedge clk);
        rst = 1'b0; wr[0] = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (resp[0]) saw = 1;
        end
        check("no resp after reset", 16'(saw), 16'h0);
        req(0, 0, 16'h0002, 2'b00, 16'h0, q, lat);
        check("aborted write", q, 16'h5555);

        // out-of-range / alias
        req(1, 0, 16'h8000, 2'b00, 16'h0, q, lat);
`ifdef DP_MEM_OOR_CHECK_EN
        check("oor read", q, 16'h0000);
`else
        check("alias read", q, 16'hC0DE);
`endif

        // randomized traffic on both ports
        fork
            rand_port(0, 60);
            rand_port(1, 60);
        join
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
